rf_wr_arbiter: RTL and testbench

- Shares the single register-file write port between the in-order WB stage and the out-of-band multi-cycle MUL/DIV unit (mdu).
- mdu results are buffered in a small FIFO. WB has priority by default; a starvation counter guarantees mdu forward progress.
- Exports a pending-destination vector so the ID stage can stall RAW/WAW hazards on buffered results.
- Sits between WB_stage/mdu and the regfile; drives WB's ready-go.

---
 rtl/rf_wr_arbiter_pkg.sv | 34 +++
 rtl/rf_wr_arbiter_arb_fifo.sv | 74 +++++++
 rtl/rf_wr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_rf_wr_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wr_arbiter_pkg.sv
// rtl/rf_wr_arbiter_pkg.sv - shared widths, mdu FIFO entry layout and grant encoding
// Optional feature macro: RF_WR_DEBUG_TRACE_EN (adds a pc field to each mdu entry)
package rf_wr_arbiter_pkg;

  localparam int GPR_ADDR_W = 5;
  localparam int GPR_DATA_W = 32;
  localparam int RF_WE_W    = 4;

`ifdef RF_WR_DEBUG_TRACE_EN
  localparam int PC_W          = 32;
  localparam int MDU_TO_ARB_WD = PC_W + GPR_DATA_W + GPR_ADDR_W;

  // dest sits in the LSBs so the FIFO can export it as a per-entry tag
  typedef struct packed {
    logic [PC_W-1:0]       pc;
    logic [GPR_DATA_W-1:0] data;
    logic [GPR_ADDR_W-1:0] dest;
  } mdu_entry_t;
`else
  localparam int MDU_TO_ARB_WD = GPR_DATA_W + GPR_ADDR_W;

  typedef struct packed {
    logic [GPR_DATA_W-1:0] data;
    logic [GPR_ADDR_W-1:0] dest;
  } mdu_entry_t;
`endif

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_WS   = 2'd1,
    GRANT_MDU  = 2'd2
  } grant_e;

endpackage

// File: rtl/rf_wr_arbiter_arb_fifo.sv
// rtl/rf_wr_arbiter_arb_fifo.sv - synchronous FIFO with flush, count and per-entry tag export
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   flush           clears pointers and count; a same-cycle push is dropped
//   push, wdata     write one entry (caller guarantees not full)
//   pop             drop the head entry (caller guarantees not empty)
//   head            oldest entry
//   count           number of valid entries
//   tags            low TAG_W bits of every storage slot
//   entry_valid     which storage slots currently hold live entries
module rf_wr_arbiter_arb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37,
  parameter int TAG_W = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             push,
  input  logic [W-1:0]                     wdata,
  input  logic                             pop,
  output logic [W-1:0]                     head,
  output logic [$clog2(DEPTH+1)-1:0]       count,
  output logic [DEPTH-1:0][TAG_W-1:0]      tags,
  output logic [DEPTH-1:0]                 entry_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [PW-1:0]             rd_ptr;
  logic [PW-1:0]             wr_ptr;
  logic [DEPTH-1:0][W-1:0]   mem;

  // DEPTH is a power of two, so pointer increments wrap for free
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

  assign head = mem[rd_ptr];

  // a slot is live when its distance from the read pointer is below count
  always_comb begin
    logic [PW-1:0] off;
    entry_valid = '0;
    tags        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off            = PW'(i) - rd_ptr;
      entry_valid[i] = CW'(off) < count;
      tags[i]        = mem[i][TAG_W-1:0];
    end
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// rtl/rf_wr_arbiter.sv - register-file write-port arbiter between WB stage and buffered mdu results
// Optional feature macro: RF_WR_DEBUG_TRACE_EN (adds ws_pc/mdu_pc and debug_wb_* trace outputs)
// Ports:
//   clk, rst                           clock, asynchronous active-low reset
//   ws_valid/ws_we/ws_dest/ws_data     WB stage write request
//   ws_ready                           WB instruction retires this cycle
//   mdu_valid/mdu_dest/mdu_data        mdu result offer
//   mdu_ready                          result FIFO has room
//   flush                              discard buffered mdu results
//   rf_we/rf_waddr/rf_wdata            regfile write port
//   pending_dest                       one-hot OR of buffered mdu destinations
module rf_wr_arbiter
  import rf_wr_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ws_valid,
  input  logic                  ws_we,
  input  logic [GPR_ADDR_W-1:0] ws_dest,
  input  logic [GPR_DATA_W-1:0] ws_data,
  output logic                  ws_ready,
  input  logic                  mdu_valid,
  input  logic [GPR_ADDR_W-1:0] mdu_dest,
  input  logic [GPR_DATA_W-1:0] mdu_data,
  output logic                  mdu_ready,
  input  logic                  flush,
  output logic [RF_WE_W-1:0]    rf_we,
  output logic [GPR_ADDR_W-1:0] rf_waddr,
  output logic [GPR_DATA_W-1:0] rf_wdata,
`ifdef RF_WR_DEBUG_TRACE_EN
  input  logic [PC_W-1:0]       ws_pc,
  input  logic [PC_W-1:0]       mdu_pc,
  output logic [PC_W-1:0]       debug_wb_pc,
  output logic [RF_WE_W-1:0]    debug_wb_rf_we,
  output logic [GPR_ADDR_W-1:0] debug_wb_rf_wnum,
  output logic [GPR_DATA_W-1:0] debug_wb_rf_wdata,
`endif
  output logic [31:0]           pending_dest
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(STARVE_LIMIT+1);

  mdu_entry_t                          push_entry;
  mdu_entry_t                          head_entry;
  logic [CW-1:0]                       count;
  logic [DEPTH-1:0][GPR_ADDR_W-1:0]    tags;
  logic [DEPTH-1:0]                    entry_valid;
  logic [SW-1:0]                       starve_cnt;
  logic                                head_valid;
  logic                                ws_req;
  logic                                mdu_prio;
  logic                                push;
  logic                                pop;
  logic                                wr_en;
  grant_e                              grant;
  logic [GPR_ADDR_W-1:0]               sel_dest;
  logic [GPR_DATA_W-1:0]               sel_data;

  assign push_entry.dest = mdu_dest;
  assign push_entry.data = mdu_data;
`ifdef RF_WR_DEBUG_TRACE_EN
  assign push_entry.pc   = mdu_pc;
`endif

  rf_wr_arbiter_arb_fifo #(
    .DEPTH (DEPTH),
    .W     (MDU_TO_ARB_WD),
    .TAG_W (GPR_ADDR_W)
  ) u_arb_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .push        (push),
    .wdata       (push_entry),
    .pop         (pop),
    .head        (head_entry),
    .count       (count),
    .tags        (tags),
    .entry_valid (entry_valid)
  );

  assign head_valid = (count != '0);
  assign mdu_ready  = (count < CW'(DEPTH));
  assign ws_req     = ws_valid && ws_we;
  assign mdu_prio   = head_valid && (starve_cnt >= SW'(STARVE_LIMIT)) && !flush;
  // flush drops the push even though mdu_ready may still read 1
  assign push       = mdu_valid && mdu_ready && !flush;
  assign pop        = (grant == GRANT_MDU);

  // Grants are held off while reset is asserted so the write port reads idle
  // immediately, not at the next clock edge.
  always_comb begin
    grant    = GRANT_NONE;
    ws_ready = ws_valid && !ws_we;
    if (rst) begin
      if (mdu_prio)                 grant = GRANT_MDU;
      else if (ws_req)              grant = GRANT_WS;
      else if (head_valid && !flush) grant = GRANT_MDU;
      if (grant == GRANT_WS) ws_ready = 1'b1;
    end
  end

  always_comb begin
    sel_dest = '0;
    sel_data = '0;
    case (grant)
      GRANT_WS: begin
        sel_dest = ws_dest;
        sel_data = ws_data;
      end
      GRANT_MDU: begin
        sel_dest = head_entry.dest;
        sel_data = head_entry.data;
      end
      default: ;
    endcase
  end

  // r0 writes still retire/pop but never reach the regfile
  assign wr_en    = (grant != GRANT_NONE) && (sel_dest != '0);
  assign rf_we    = wr_en ? {RF_WE_W{1'b1}} : '0;
  assign rf_waddr = wr_en ? sel_dest : '0;
  assign rf_wdata = wr_en ? sel_data : '0;

  // Counts cycles the head has waited; saturates at the limit until popped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (flush || !head_valid || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_comb begin
    pending_dest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pending_dest[tags[i]] = 1'b1;
    end
    pending_dest[0] = 1'b0;
  end

`ifdef RF_WR_DEBUG_TRACE_EN
  always_comb begin
    debug_wb_pc       = '0;
    debug_wb_rf_we    = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    if (rst) begin
      if (grant != GRANT_NONE) begin
        debug_wb_pc       = (grant == GRANT_WS) ? ws_pc : head_entry.pc;
        debug_wb_rf_we    = rf_we;
        debug_wb_rf_wnum  = rf_waddr;
        debug_wb_rf_wdata = rf_wdata;
      end else if (ws_valid && !ws_we) begin
        debug_wb_pc = ws_pc;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// tb/tb_rf_wr_arbiter.sv - self-checking bench for rf_wr_arbiter against a queue-based model
module tb_rf_wr_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ws_valid, ws_we;
  logic [4:0]  ws_dest;
  logic [31:0] ws_data;
  logic        ws_ready;
  logic        mdu_valid;
  logic [4:0]  mdu_dest;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        flush;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending_dest;

  always #5 clk = ~clk;

  rf_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .ws_valid     (ws_valid),
    .ws_we        (ws_we),
    .ws_dest      (ws_dest),
    .ws_data      (ws_data),
    .ws_ready     (ws_ready),
    .mdu_valid    (mdu_valid),
    .mdu_dest     (mdu_dest),
    .mdu_data     (mdu_data),
    .mdu_ready    (mdu_ready),
    .flush        (flush),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .pending_dest (pending_dest)
  );

  typedef struct {
    logic [4:0]  dest;
    logic [31:0] data;
  } ent_t;

  int          n_chk  = 0;
  int          n_pass = 0;
  ent_t        q[$];
  int          starve;
  logic [4:0]  mdu_log[$];
  bit          last_push;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One clock cycle: drive at negedge, compare settled outputs against the
  // model, then advance the model to what the next posedge must produce.
  task automatic step(input logic wv, input logic we, input logic [4:0] wd, input logic [31:0] wdat,
                      input logic mv, input logic [4:0] md, input logic [31:0] mdat, input logic fl);
    bit          head, prio, g_ws, g_mdu, wr, rdy;
    logic [4:0]  a;
    logic [31:0] d, pend;
    @(negedge clk);
    ws_valid = wv; ws_we = we; ws_dest = wd; ws_data = wdat;
    mdu_valid = mv; mdu_dest = md; mdu_data = mdat; flush = fl;
    #1;
    head = (q.size() > 0);
    rdy  = (q.size() < DEPTH);
    prio = head && (starve >= LIMIT) && !fl;
    g_ws = 0; g_mdu = 0;
    if (prio)             g_mdu = 1;
    else if (wv && we)    g_ws  = 1;
    else if (head && !fl) g_mdu = 1;
    a = '0; d = '0;
    if (g_ws)       begin a = wd; d = wdat; end
    else if (g_mdu) begin a = q[0].dest; d = q[0].data; end
    wr = (g_ws || g_mdu) && (a != 0);
    if (!wr) begin a = '0; d = '0; end
    pend = '0;
    foreach (q[i]) pend[q[i].dest] = 1'b1;
    pend[0] = 1'b0;
    chk("m_ws_ready",  ws_ready, (wv && !we) || g_ws);
    chk("m_mdu_ready", mdu_ready, rdy);
    chk("m_rf_we",     rf_we, wr ? 4'hF : 4'h0);
    chk("m_rf_waddr",  rf_waddr, a);
    chk("m_rf_wdata",  rf_wdata, d);
    chk("m_pending",   pending_dest, pend);
    if (g_mdu) mdu_log.push_back(q[0].dest);
    last_push = mv && rdy && !fl;
    if (fl) begin
      q.delete();
      starve = 0;
    end else begin
      if (!head || g_mdu) starve = 0;
      else if (starve < LIMIT) starve++;
      if (g_mdu) void'(q.pop_front());
      if (last_push) q.push_back('{md, mdat});
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) idle();
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    logic [4:0] items [3];
    int k;
    rst = 1'b0; flush = 0; mdu_valid = 0; mdu_dest = 0; mdu_data = 0;
    ws_valid = 1; ws_we = 0; ws_dest = 5'd5; ws_data = 32'hDEAD;
    q.delete(); starve = 0;
    #3;
    chk("rst_rf_we",     rf_we, 0);
    chk("rst_waddr",     rf_waddr, 0);
    chk("rst_wdata",     rf_wdata, 0);
    chk("rst_pending",   pending_dest, 0);
    chk("rst_mdu_ready", mdu_ready, 1);
    chk("rst_ws_ready_nowe", ws_ready, 1);
    ws_we = 1; #1;
    chk("rst_ws_ready_we", ws_ready, 0);
    chk("rst_rf_we_req",   rf_we, 0);
    @(negedge clk); ws_valid = 0; ws_we = 0;
    rst = 1'b1;

    // plain WB write
    step(1, 1, 5, 32'h1234, 0, 0, 0, 0);
    chk("t1_rf_we", rf_we, 4'hF);
    chk("t1_waddr", rf_waddr, 5);
    chk("t1_wdata", rf_wdata, 32'h1234);
    chk("t1_ws_ready", ws_ready, 1);

    // single mdu result, no bypass
    step(0, 0, 0, 0, 1, 7, 32'hAA, 0);
    chk("t2_push_cycle_we", rf_we, 0);
    idle();
    chk("t2_pending", pending_dest, 32'h80);
    chk("t2_rf_we", rf_we, 4'hF);
    chk("t2_waddr", rf_waddr, 7);
    chk("t2_wdata", rf_wdata, 32'hAA);
    idle();
    chk("t2_pending_clr", pending_dest, 0);
    chk("t2_rf_we_idle", rf_we, 0);

    // starvation: head wins on the 5th cycle after the push
    step(1, 1, 3, 32'h33, 1, 9, 32'h99, 0);
    for (int c = 1; c <= 4; c++) begin
      step(1, 1, 3, 32'h33, 0, 0, 0, 0);
      chk("t3_ws_wins", rf_waddr, 3);
    end
    step(1, 1, 3, 32'h33, 0, 0, 0, 0);
    chk("t3_mdu_waddr", rf_waddr, 9);
    chk("t3_ws_stall", ws_ready, 0);
    step(1, 1, 3, 32'h33, 0, 0, 0, 0);
    chk("t3_ws_after", rf_waddr, 3);
    chk("t3_ws_ready_after", ws_ready, 1);
    drain();

    // back-pressure and ordering with continuous WB writes
    mdu_log.delete();
    items[0] = 5'd10; items[1] = 5'd11; items[2] = 5'd12;
    k = 0;
    for (int s = 0; s < 40 && (k < 3 || q.size() > 0); s++) begin
      step(1, 1, 4, 32'h4444, k < 3, (k < 3) ? items[k] : 5'd0, 32'h100 + k, 0);
      if (s == 2) chk("t4_full", mdu_ready, 0);
      if (last_push) k++;
    end
    chk("t4_all_pushed", k, 3);
    chk("t4_log_size", mdu_log.size(), 3);
    if (mdu_log.size() == 3) begin
      chk("t4_order_a", mdu_log[0], 10);
      chk("t4_order_b", mdu_log[1], 11);
      chk("t4_order_c", mdu_log[2], 12);
    end
    drain();

    // r0 writes retire/pop without enabling the regfile
    step(1, 1, 0, 32'h5, 1, 0, 32'h50, 0);
    chk("t5_ws_r0_we", rf_we, 0);
    chk("t5_ws_r0_ready", ws_ready, 1);
    step(1, 1, 1, 32'h1, 1, 0, 32'h51, 0);
    idle();
    chk("t5_full", mdu_ready, 0);
    chk("t5_mdu_r0_we", rf_we, 0);
    chk("t5_pending_r0", pending_dest, 0);
    idle();
    chk("t5_count_dec", mdu_ready, 1);
    chk("t5_mdu_r0_we2", rf_we, 0);
    drain();

    // flush with a buffered pair and a same-cycle offer
    step(1, 1, 6, 32'h66, 1, 13, 32'h13, 0);
    step(1, 1, 6, 32'h66, 1, 14, 32'h14, 0);
    step(1, 1, 2, 32'h2222, 1, 15, 32'h15, 1);
    chk("t6_pending_pre", pending_dest, 32'h6000);
    chk("t6_ws_proceeds", rf_waddr, 2);
    chk("t6_ws_we", rf_we, 4'hF);
    idle();
    chk("t6_pending_post", pending_dest, 0);
    chk("t6_no_fifo_write", rf_we, 0);
    chk("t6_ready_post", mdu_ready, 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 5'($urandom), $urandom,
           $urandom_range(0, 1) == 1, 5'($urandom), $urandom, $urandom_range(0, 19) == 0);
    end
    drain();

    // asynchronous reset mid-operation
    step(1, 1, 8, 32'h88, 1, 20, 32'h20, 0);
    step(1, 1, 8, 32'h88, 1, 21, 32'h21, 0);
    step(1, 1, 8, 32'h88, 0, 0, 0, 0);
    chk("t7_pending_pre", pending_dest, 32'h0030_0000);
    @(negedge clk);
    ws_valid = 1; ws_we = 1; ws_dest = 8; ws_data = 32'h88; mdu_valid = 0; flush = 0;
    #2 rst = 1'b0;
    #1;
    chk("t7_rf_we",     rf_we, 0);
    chk("t7_waddr",     rf_waddr, 0);
    chk("t7_wdata",     rf_wdata, 0);
    chk("t7_pending",   pending_dest, 0);
    chk("t7_mdu_ready", mdu_ready, 1);
    chk("t7_ws_ready",  ws_ready, 0);
    q.delete(); starve = 0;
    @(negedge clk); ws_valid = 0; ws_we = 0;
    rst = 1'b1;
    idle();
    chk("t7_post_we", rf_we, 0);
    step(1, 1, 9, 32'h9, 0, 0, 0, 0);
    chk("t7_post_ws", rf_waddr, 9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
